// File: rtl/plateau_detect_pkg.sv
// rtl/plateau_detect_pkg.sv - shared FSM encoding and threshold format for plateau_detect
package plateau_detect_pkg;

    localparam int THRES_FRAC_BITS = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_PLATEAU = 2'd2,
        ST_HOLDOFF = 2'd3
    } pd_state_t;

endpackage

// File: rtl/plateau_detect_thres_compare.sv
// rtl/plateau_detect_thres_compare.sv - clamp, scale and strict compare pipeline (two stages)
module thres_compare
    import plateau_detect_pkg::*;
#(
    parameter int SUM_WIDTH0 = 22,
    parameter int SUM_WIDTH1 = 22
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic signed [SUM_WIDTH0-1:0] corr_sum,
    input  logic signed [SUM_WIDTH1-1:0] pwr_sum,
    input  logic                         sum_valid,
    input  logic [7:0]                   thres_scale,
    output logic                         qual_valid,
    output logic                         qualify
);

    localparam int SW = (SUM_WIDTH0 > SUM_WIDTH1) ? SUM_WIDTH0 : SUM_WIDTH1;
    localparam int W  = SW + 8;

    logic [SUM_WIDTH0-1:0] corr_u;
    logic [SUM_WIDTH1-1:0] pwr_u;
    logic [W-1:0]          a_nxt, b_nxt;
    logic [W-1:0]          a_r, b_r;
    logic                  v1_r;

    // Negative sums carry no energy, so they count as zero on both sides.
    always_comb begin
        corr_u = corr_sum[SUM_WIDTH0-1] ? '0 : $unsigned(corr_sum);
        pwr_u  = pwr_sum[SUM_WIDTH1-1]  ? '0 : $unsigned(pwr_sum);
        a_nxt  = {{(W-SUM_WIDTH0){1'b0}}, corr_u} << THRES_FRAC_BITS;
        b_nxt  = W'(pwr_u) * W'(thres_scale);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_r        <= '0;
            b_r        <= '0;
            v1_r       <= 1'b0;
            qualify    <= 1'b0;
            qual_valid <= 1'b0;
        end else begin
            if (sum_valid) begin
                a_r <= a_nxt;
                b_r <= b_nxt;
            end
            v1_r       <= sum_valid;
            qualify    <= v1_r && (a_r > b_r);
            qual_valid <= v1_r;
        end
    end

endmodule

// File: rtl/plateau_detect.sv
// rtl/plateau_detect.sv - plateau detector FSM with run-length and holdoff counters
module plateau_detect
    import plateau_detect_pkg::*;
#(
    parameter int SUM_WIDTH0 = 22,
    parameter int SUM_WIDTH1 = 22,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic signed [SUM_WIDTH0-1:0] corr_sum,
    input  logic signed [SUM_WIDTH1-1:0] pwr_sum,
    input  logic                         sum_valid,
    input  logic                         enable,
    input  logic [7:0]                   thres_scale,
    input  logic [CNT_WIDTH-1:0]         min_plateau_len,
    input  logic [CNT_WIDTH-1:0]         holdoff_len,
    output logic                         detected,
    output logic                         plateau_active,
    output logic [CNT_WIDTH-1:0]         plateau_count
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic                 qual_valid, qualify;
    pd_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt, hold, hold_nxt, target, run_len;
    logic                 det_nxt;

    thres_compare #(
        .SUM_WIDTH0 (SUM_WIDTH0),
        .SUM_WIDTH1 (SUM_WIDTH1)
    ) u_thres_compare (
        .clk         (clk),
        .rstn        (rstn),
        .corr_sum    (corr_sum),
        .pwr_sum     (pwr_sum),
        .sum_valid   (sum_valid),
        .thres_scale (thres_scale),
        .qual_valid  (qual_valid),
        .qualify     (qualify)
    );

    assign plateau_active = (state == ST_PLATEAU);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            plateau_count <= '0;
            hold          <= '0;
            detected      <= 1'b0;
        end else begin
            state         <= state_nxt;
            plateau_count <= cnt_nxt;
            hold          <= hold_nxt;
            detected      <= det_nxt;
        end
    end

    // A length of 0 behaves like 1; the count saturates instead of wrapping.
    always_comb begin
        target  = (min_plateau_len == '0) ? ONE : min_plateau_len;
        run_len = ONE;
        if (state == ST_PLATEAU)
            run_len = (&plateau_count) ? plateau_count : plateau_count + ONE;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = plateau_count;
        hold_nxt  = hold;
        det_nxt   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_SEARCH;
                ST_SEARCH, ST_PLATEAU: begin
                    if (qual_valid) begin
                        if (qualify) begin
                            cnt_nxt = run_len;
                            if (run_len >= target) begin
                                det_nxt   = 1'b1;
                                hold_nxt  = holdoff_len;
                                state_nxt = ST_HOLDOFF;
                            end else begin
                                state_nxt = ST_PLATEAU;
                            end
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (qual_valid) begin
                        if (hold == '0) begin
                            state_nxt = ST_SEARCH;
                            cnt_nxt   = '0;
                        end else begin
                            hold_nxt = hold - ONE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plateau_detect.sv
// tb/tb_plateau_detect.sv - scoreboard bench for plateau_detect
module tb_plateau_detect;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [21:0] corr_sum = '0;
    logic signed [21:0] pwr_sum = '0;
    logic               sum_valid = 1'b0;
    logic               enable = 1'b0;
    logic [7:0]         thres_scale = 8'd96;
    logic [15:0]        min_plateau_len = 16'd16;
    logic [15:0]        holdoff_len = 16'd0;
    logic               detected;
    logic               plateau_active;
    logic [15:0]        plateau_count;

    plateau_detect dut (
        .clk             (clk),
        .rstn            (rstn),
        .corr_sum        (corr_sum),
        .pwr_sum         (pwr_sum),
        .sum_valid       (sum_valid),
        .enable          (enable),
        .thres_scale     (thres_scale),
        .min_plateau_len (min_plateau_len),
        .holdoff_len     (holdoff_len),
        .detected        (detected),
        .plateau_active  (plateau_active),
        .plateau_count   (plateau_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit det;
        int cnt;
        bit act;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(string name, int actual, int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: each sample's outcome is due 2 edges after the edge that captured it.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("detected", int'(detected), int'(e.det));
            check("plateau_count", int'(plateau_count), e.cnt);
            check("plateau_active", int'(plateau_active), int'(e.act));
        end else if (detected) begin
            check("stray_detected", int'(detected), 0);
        end
    end

    task automatic send(int c, int p, bit d, int n, bit a);
        exp_t x;
        @(negedge clk);
        corr_sum  = 22'(c);
        pwr_sum   = 22'(p);
        sum_valid = 1'b1;
        x.due = cyc + 3;
        x.det = d;
        x.cnt = n;
        x.act = a;
        q.push_back(x);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            sum_valid = 1'b0;
        end
    endtask

    task automatic restart(int thr, int mn, int ho);
        idle(4);
        enable = 1'b0;
        idle(2);
        thres_scale     = 8'(thr);
        min_plateau_len = 16'(mn);
        holdoff_len     = 16'(ho);
        enable          = 1'b1;
        idle(2);
    endtask

    initial begin
        idle(3);
        check("reset_detected", int'(detected), 0);
        check("reset_active", int'(plateau_active), 0);
        check("reset_count", int'(plateau_count), 0);
        rstn = 1'b1;

        // 20 qualifying samples, holdoff 0: one detection on sample 16
        restart(96, 16, 0);
        for (int i = 1; i <= 20; i++)
            send(1000, 1000, i == 16, (i <= 16) ? i : ((i == 17) ? 0 : i - 17), (i < 16) || (i >= 18));

        // threshold boundary, zero sums, negative clamps, min length 0
        restart(96, 0, 0);
        send(1000, 1334, 0, 0, 0);
        send(1000, 1333, 1, 1, 0);
        send(1000, 1333, 0, 0, 0);
        send(1000, 1333, 1, 1, 0);
        send(0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0);
        send(-5000, 0, 0, 0, 0);
        send(-5000, -100, 0, 0, 0);
        send(1, -7, 1, 1, 0);

        // broken run: 10 good, 1 bad, 16 good -> detection on sample 27
        restart(96, 16, 0);
        for (int i = 1; i <= 10; i++) send(1000, 1000, 0, i, 1);
        send(1000, 2000, 0, 0, 0);
        for (int i = 1; i <= 16; i++) send(1000, 1000, i == 16, i, i < 16);

        // holdoff 8: detections on samples 16 and 41
        restart(96, 16, 8);
        for (int i = 1; i <= 45; i++)
            send(1000, 1000, (i == 16) || (i == 41),
                 (i <= 16) ? i : (i <= 24) ? 16 : (i == 25) ? 0 : (i <= 41) ? i - 25 : 16,
                 (i < 16) || (i >= 26 && i < 41));

        // lowering min length below the current run detects on the next sample
        restart(96, 16, 0);
        for (int i = 1; i <= 5; i++) send(1000, 1000, 0, i, 1);
        idle(4);
        min_plateau_len = 16'd3;
        send(1000, 1000, 1, 6, 0);

        // sum_valid every other cycle, then enable dropped mid-plateau
        restart(96, 16, 0);
        for (int i = 1; i <= 22; i++) begin
            send(1000, 1000, i == 16, (i <= 16) ? i : i - 17, (i < 16) || (i >= 18));
            idle(1);
        end
        idle(4);
        check("midplateau_active", int'(plateau_active), 1);
        check("midplateau_count", int'(plateau_count), 5);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_active", int'(plateau_active), 0);
        check("disable_count", int'(plateau_count), 0);

        // reset one cycle after the 16th sample: in-flight samples are dropped
        restart(96, 16, 0);
        for (int i = 1; i <= 16; i++) send(1000, 1000, 0, (i <= 14) ? i : 0, i <= 14);
        @(negedge clk);
        sum_valid = 1'b0;
        rstn      = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(6);
        check("postreset_detected", int'(detected), 0);
        check("postreset_active", int'(plateau_active), 0);
        check("postreset_count", int'(plateau_count), 0);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) check("scoreboard_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plateau_detect.md
PLATEAU_DETECT -- requirements
Module: plateau_detect

Interface
REQ-001 SHALL have parameter SUM_WIDTH0, default 22, meaning width of the signed correlation-magnitude running sum.
REQ-002 SHALL have parameter SUM_WIDTH1, default 22, meaning width of the signed power running sum.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the plateau and holdoff counters.
REQ-004 SHALL have port clk, input, 1, the clock; all logic is rising-edge.
REQ-005 SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port corr_sum, input, SUM_WIDTH0 signed, the correlation running sum from the upstream dual-channel running-sum stage (channel 0).
REQ-007 SHALL have port pwr_sum, input, SUM_WIDTH1 signed, the power running sum from the same stage (channel 1).
REQ-008 SHALL have port sum_valid, input, 1, qualifying both sums.
REQ-009 SHALL have port enable, input, 1, detector run enable.
REQ-010 SHALL have port thres_scale, input, 8 unsigned, threshold in Q1.7 format (128 = 1.0).
REQ-011 SHALL have port min_plateau_len, input, CNT_WIDTH, consecutive qualifying samples needed to detect.
REQ-012 SHALL have port holdoff_len, input, CNT_WIDTH, valid samples ignored after a detection.
REQ-013 SHALL have port detected, output, 1, a one-cycle detection pulse.
REQ-014 SHALL have port plateau_active, output, 1, high while state = PLATEAU.
REQ-015 SHALL have port plateau_count, output, CNT_WIDTH, the current run length.

Function
REQ-016 SHALL clamp negative corr_sum and pwr_sum to zero before comparison.
REQ-017 Stage 1 SHALL register, on sum_valid, a = clamp(corr_sum)*128 and b = clamp(pwr_sum)*thres_scale at full width (max(SUM_WIDTH0,SUM_WIDTH1)+8 bits, no truncation), plus a valid flag.
REQ-018 Stage 2 SHALL evaluate qualify = (a > b) using strict comparison, so a sample with both sums zero never qualifies.
REQ-019 SHALL advance the FSM and counters only on stage-2 valid cycles; gaps in sum_valid SHALL NOT break a plateau.
REQ-020 SHALL implement FSM states IDLE, SEARCH, PLATEAU and HOLDOFF.
REQ-021 SHALL force state to IDLE with plateau_count = 0 whenever enable = 0, taking priority over all other transitions.
REQ-022 SHALL move IDLE to SEARCH on the first cycle in which enable = 1.
REQ-023 In SEARCH, a qualifying sample SHALL set count = 1 and go to PLATEAU; a non-qualifying sample SHALL hold SEARCH.
REQ-024 In PLATEAU, a qualifying sample SHALL increment the count; a non-qualifying sample SHALL clear the count and return to SEARCH.
REQ-025 SHALL, when the count reaches max(min_plateau_len,1), pulse detected for one cycle, load the holdoff counter with holdoff_len and enter HOLDOFF, including the case of a single sample when the length is 0 or 1.
REQ-026 SHALL make the detection latency 2 clk cycles from the sum_valid of the completing sample to detected = 1.
REQ-027 In HOLDOFF, each valid sample SHALL decrement the holdoff counter and the qualify result SHALL be ignored.
REQ-028 SHALL move HOLDOFF to SEARCH, with count = 0, on the valid sample that finds the holdoff counter already 0, so holdoff_len = 0 costs exactly one sample.
REQ-029 SHALL saturate plateau_count at all-ones and never wrap it.
REQ-030 SHALL sample min_plateau_len continuously; lowering it below the current count SHALL cause detection on the next qualifying sample.

Reset
REQ-031 SHALL, on rstn = 0, clear state to IDLE and clear detected, plateau_active, plateau_count, the holdoff counter, the stage-1/2 registers and the valid flags.
REQ-032 SHALL discard any in-flight pipeline sample on a mid-operation reset and produce no detected pulse afterwards.

Structure
REQ-033 SHALL place the FSM state encoding (2 bits) and THRES_FRAC_BITS = 7 in the shared package/header used by the sync stages.
REQ-034 SHALL isolate the clamp, scale and compare pipeline (stages 1-2) in one sub-module, thres_compare; the FSM and counters stay in plateau_detect.

Verification
REQ-035 SHALL verify: thres_scale=96, min_len=16, holdoff=0, 20 valid samples corr=1000, pwr=1000 -> detected exactly once, 2 cycles after the 16th sum_valid.
REQ-036 SHALL verify: corr=1000, pwr=1334, thres_scale=96 (a=128000 < b=128064) -> no detection; pwr=1333 (b=127968) -> detection.
REQ-037 SHALL verify: 10 qualifying samples, 1 non-qualifying sample, then 16 qualifying samples with min_len=16 -> plateau_count returns to 0, then a single detection on the 27th sample.
REQ-038 SHALL verify: holdoff=8 with a continuous qualifying stream -> detections on samples 16 and 41.
REQ-039 SHALL verify: qualifying stream with sum_valid toggling every other cycle -> detection on the 16th valid sample; enable dropped mid-plateau -> IDLE, count 0.
REQ-040 SHALL verify: rstn asserted 1 cycle after the 16th sum_valid -> no detected pulse, all outputs 0; negative corr_sum = -5000 -> never qualifies.
